// File: rtl/sbc_accumulator.sv
// sbc_accumulator: counts 1s of a unipolar stochastic stream over a 2^WIN_LOG2-cycle window
// and emits the scaled, saturated count as a BW-bit binary value with a one-cycle valid pulse.
module sbc_accumulator #(
    parameter int BW       = 4,
    parameter int WIN_LOG2 = 4
) (
    input  logic          i_clk_sbc,
    input  logic          i_rst_sbc,
    input  logic          i_start_sbc,
    input  logic          i_stop_sbc,
    input  logic          i_sn_bit,
    output logic [BW-1:0] o_x_bn,
    output logic          o_valid_sbc,
    output logic          o_busy_sbc
);
    localparam int CW = WIN_LOG2 + 1;
    localparam logic [CW-1:0] LAST = CW'((1 << WIN_LOG2) - 1);
    localparam logic [CW-1:0] MAXV = CW'((1 << BW) - 1);

    if (WIN_LOG2 < BW) begin : g_param_chk
        $error("sbc_accumulator: WIN_LOG2 must be >= BW");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1} state_t;

    state_t        state, state_n;
    logic [CW-1:0] win_cnt, win_n, ones_cnt, ones_n, ones_inc, scaled;
    logic [BW-1:0] x_n;
    logic          valid_n;

    assign ones_inc   = ones_cnt + CW'(i_sn_bit);
    assign scaled     = ones_inc >> (WIN_LOG2 - BW);
    assign o_busy_sbc = state == COUNT;

    always_comb begin
        state_n = state;
        win_n   = win_cnt;
        ones_n  = ones_cnt;
        x_n     = o_x_bn;
        valid_n = 1'b0;
        case (state)
            IDLE: begin
                if (i_start_sbc) begin
                    state_n = COUNT;
                    win_n   = '0;
                    ones_n  = '0;
                end
            end
            COUNT: begin
                if (i_stop_sbc) begin
                    state_n = IDLE;
                    win_n   = '0;
                    ones_n  = '0;
                end else if (win_cnt == LAST) begin
                    // A start on the completion edge chains straight into the next window
                    state_n = i_start_sbc ? COUNT : IDLE;
                    win_n   = '0;
                    ones_n  = '0;
                    x_n     = scaled > MAXV ? MAXV[BW-1:0] : scaled[BW-1:0];
                    valid_n = 1'b1;
                end else if (i_start_sbc) begin
                    win_n  = '0;
                    ones_n = '0;
                end else begin
                    win_n  = win_cnt + 1'b1;
                    ones_n = ones_inc;
                end
            end
            default: begin
                state_n = IDLE;
                win_n   = '0;
                ones_n  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk_sbc or negedge i_rst_sbc) begin
        if (!i_rst_sbc) begin
            state       <= IDLE;
            win_cnt     <= '0;
            ones_cnt    <= '0;
            o_x_bn      <= '0;
            o_valid_sbc <= 1'b0;
        end else begin
            state       <= state_n;
            win_cnt     <= win_n;
            ones_cnt    <= ones_n;
            o_x_bn      <= x_n;
            o_valid_sbc <= valid_n;
        end
    end
endmodule

// File: tb/tb_sbc_accumulator.sv
// tb_sbc_accumulator: directed checks of the stochastic-to-binary converter at default
// parameters and at WIN_LOG2=6, BW=4.
module tb_sbc_accumulator;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0, sn = 1'b0;
    logic [3:0] x;
    logic       valid, busy;
    logic       start2 = 1'b0, stop2 = 1'b0, sn2 = 1'b0;
    logic [3:0] x2;
    logic       valid2, busy2;
    int         n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    sbc_accumulator dut (
        .i_clk_sbc(clk), .i_rst_sbc(rst_n), .i_start_sbc(start), .i_stop_sbc(stop),
        .i_sn_bit(sn), .o_x_bn(x), .o_valid_sbc(valid), .o_busy_sbc(busy)
    );

    sbc_accumulator #(.BW(4), .WIN_LOG2(6)) dut2 (
        .i_clk_sbc(clk), .i_rst_sbc(rst_n), .i_start_sbc(start2), .i_stop_sbc(stop2),
        .i_sn_bit(sn2), .o_x_bn(x2), .o_valid_sbc(valid2), .o_busy_sbc(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic window(input logic [15:0] p, input int exp, input bit do_start, input bit end_start);
        logic early = 1'b0;
        if (do_start) begin
            start = 1'b1;
            sn    = 1'b1;
            tick();
            start = 1'b0;
        end
        for (int i = 15; i >= 0; i--) begin
            sn = p[i];
            if (i == 0) start = end_start;
            tick();
            if (i != 0) early |= valid;
        end
        start = 1'b0;
        sn    = 1'b0;
        chk("early_valid", 32'(early), 0);
        chk("valid", 32'(valid), 1);
        chk("x", 32'(x), 32'(exp));
        chk("busy_after", 32'(busy), 32'(end_start));
    endtask

    task automatic window64(input logic [63:0] p, input int exp);
        logic early = 1'b0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            sn2 = p[i];
            tick();
            if (i != 0) early |= valid2;
        end
        sn2 = 1'b0;
        chk("w64_early_valid", 32'(early), 0);
        chk("w64_valid", 32'(valid2), 1);
        chk("w64_x", 32'(x2), 32'(exp));
        chk("w64_busy", 32'(busy2), 0);
        tick();
        chk("w64_valid_drop", 32'(valid2), 0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_x", 32'(x), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 0);

        window(16'hFFFF, 15, 1, 0);
        tick();
        chk("valid_pulse_one_cycle", 32'(valid), 0);
        chk("x_hold", 32'(x), 15);

        window(16'h6126, 6, 1, 0);
        tick();
        chk("idle_after_window", 32'(busy), 0);
        window(16'h0000, 0, 1, 0);
        window(16'h6126, 6, 1, 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("count_busy", 32'(busy), 1);
        for (int i = 0; i < 8; i++) begin
            sn = 1'b1;
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        sn = 1'b0;
        chk("stop_busy", 32'(busy), 0);
        chk("stop_valid", 32'(valid), 0);
        for (int i = 0; i < 10; i++) tick();
        chk("stop_no_late_valid", 32'(valid), 0);
        chk("stop_x_kept", 32'(x), 6);
        window(16'h00FF, 8, 1, 0);

        start = 1'b1;
        sn = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        window(16'h0007, 3, 1, 0);

        window(16'hFFFF, 15, 1, 1);
        window(16'h0003, 2, 0, 0);

        window64({40'hFF_FFFF_FFFF, 24'h0}, 10);
        window64({64{1'b1}}, 15);

        start = 1'b1;
        tick();
        start = 1'b0;
        sn = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_x", 32'(x), 0);
        chk("async_rst_valid", 32'(valid), 0);
        chk("async_rst_busy", 32'(busy), 0);
        tick();
        rst_n = 1'b1;
        sn = 1'b0;
        begin
            logic spur = 1'b0;
            for (int i = 0; i < 20; i++) begin
                tick();
                spur |= valid;
            end
            chk("no_spurious_valid", 32'(spur), 0);
        end
        start = 1'b1;
        stop = 1'b1;
        tick();
        chk("idle_start_stop_busy", 32'(busy), 1);
        tick();
        start = 1'b0;
        stop = 1'b0;
        chk("count_start_stop_busy", 32'(busy), 0);
        chk("count_start_stop_valid", 32'(valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
